kbd_char_feeder: RTL
====================

Name: kbd_char_feeder

Overview:
- Upstream feeder for the video terminal: buffers ASCII bytes from a byte source (UART receiver or keyboard scanner) in a small FIFO.
- Presents one character at a time on rd[7:1] and da, using the Apple-1 keyboard handshake.
- The terminal acknowledges each character with an active-low rda_n pulse; this block then retires the character and presents the next.
- rda_n is produced in the terminal's derived mem_phi domain, so this block synchronises it to clk.

Parameters:
- FIFO_DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- GAP_CYCLES, 4, minimum clk cycles da stays low between two presented characters; minimum 1.
- ACK_TIMEOUT, 0, clk cycles to wait for an rda_n acknowledge before abandoning the character; 0 = wait forever.

Ports:
- clk  input  1  system clock (same clock that drives the terminal).
- mr_n  input  1  master reset, asynchronous, active-low.
- in_data  input  8  source byte; bit 7 is ignored.
- in_valid  input  1  source byte valid.
- in_ready  output  1  FIFO can accept a byte; equals not-full.
- rd  output  7  character to terminal, rd[7:1] = ASCII[6:0].
- da  output  1  data available to terminal, active-high.
- rda_n  input  1  terminal acknowledge, active-low, asynchronous to clk.
- fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- ack_timeout  output  1  sticky flag: set when a character was abandoned; cleared only by reset.

Behaviour:
- Reset (mr_n low, asynchronous): FIFO empty, fifo_level=0, in_ready=1, rd=0, da=0, ack_timeout=0, FSM=IDLE, rda_n synchroniser flops preset to 1.
- Push: a byte is written when in_valid and in_ready are both high on a clk edge. A byte offered while the FIFO is full waits at the source; nothing is dropped.
- in_ready is not-full of the current state. There is no same-cycle push-through when the FIFO is full and a pop occurs in the same cycle.
- rda_n is passed through a 2-flop synchroniser to give rsync_n. The FSM acts only on rsync_n.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the rd register and go to PRESENT. da=0.
  - PRESENT: da=1 and rd holds steady. If rsync_n=0, go to RELEASE. If ACK_TIMEOUT>0 and the wait counter reaches ACK_TIMEOUT, set ack_timeout and go to RELEASE.
  - RELEASE: da=0. Wait for rsync_n=1, then load the gap counter and go to GAP.
  - GAP: da=0. Count GAP_CYCLES, then go to IDLE.
- Latency: a push at edge N into an empty FIFO, with the FSM in IDLE, gives da=1 after edge N+2, with rd valid in the same cycle.
- rd holds the last presented character after da falls. rd changes only on the IDLE pop.
- Acknowledge:
  - An rda_n low pulse of at least 2 clk cycles is always detected.
  - An rda_n low seen while in IDLE or GAP is ignored.
  - An rda_n held low across the return to IDLE does not acknowledge the next character; RELEASE requires rda_n to have returned high.
- Simultaneous push and pop on the same edge: occupancy is unchanged and fifo_level is stable.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- Reset in the middle of PRESENT: da drops immediately and the buffered characters are lost.

Optional Feature:
- Macro: KBD_UPCASE_EN.
- Defined: bytes 0x61..0x7A ('a'..'z') have bit 5 cleared before storage into the FIFO (for example 0x61 becomes 0x41). Also, 0x0A (LF) is discarded at the push: it is accepted with in_ready but never stored. This matches the Apple-1 uppercase-only terminal and CR-only newline convention.
- Undefined: in_data[6:0] is stored unchanged.

Test Plan:
- Reset, push 0x41; hold rda_n high -> da=1 with rd=7'h41 two cycles after the push; da stays high indefinitely (ACK_TIMEOUT=0).
- With 0x41 presented, pulse rda_n low for 3 clk cycles -> da=0 within 3 cycles of the falling edge; next character appears no sooner than GAP_CYCLES after rda_n returns high.
- Push 17 bytes 0x30..0x40 back-to-back with no acks (FIFO_DEPTH=16) -> in_ready=0 after the 17th offered byte (one byte was popped to rd); fifo_level=16; acking each in turn yields rd 0x30..0x40 in order.
- Hold rda_n low continuously with 2 bytes queued -> the first is acked; the FSM stalls in RELEASE and the second is not presented until rda_n goes high.
- ACK_TIMEOUT=100, push 0x0D, no ack -> da falls after 100 cycles in PRESENT; ack_timeout=1 and stays 1 until mr_n is asserted.
- KBD_UPCASE_EN defined: push 0x61, 0x0A, 0x7A -> presented rd sequence is 0x41, 0x5A; LF is never presented.

Source files
------------

// File: rtl/kbd_char_feeder_if.sv
// Byte-source inputs plus Apple-1 keyboard handshake (rd/da/rda_n) and status for kbd_char_feeder.
interface kbd_char_feeder_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [7:1]    rd;
   logic          da;
   logic          rda_n;
   logic [LW-1:0] fifo_level;
   logic          ack_timeout;

   modport master (
      output in_data, in_valid, rda_n,
      input  in_ready, rd, da, fifo_level, ack_timeout
   );

   modport slave (
      input  in_data, in_valid, rda_n,
      output in_ready, rd, da, fifo_level, ack_timeout
   );
endinterface

// File: rtl/kbd_char_feeder.sv
// FIFO-buffered ASCII feeder for the Apple-1 keyboard port: push->da in 2 edges, source stalls on full (in_ready).
// KBD_UPCASE_EN: fold 'a'..'z' to upper case and drop LF at the push.
module kbd_char_feeder #(
   parameter int FIFO_DEPTH  = 16,
   parameter int GAP_CYCLES  = 4,
   parameter int ACK_TIMEOUT = 0
) (
   input  logic             clk,
   input  logic             mr_n,
   kbd_char_feeder_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_RELEASE, ST_GAP} state_t;

   logic [6:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   state_t        state_q, state_d;
   logic [6:0]    rd_q, rd_d;
   logic          da_q, da_d;
   logic          ack_to_q, ack_to_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [TW-1:0] wait_q, wait_d;
   logic          sync1_q, rsync_n_q;

   logic [6:0]    push_dat;
   logic          push_keep;
   logic          full;
   logic          push_fire;
   logic          wr_en;
   logic          pop;
   logic          unused_in_b7;

   assign unused_in_b7 = bus.in_data[7];

   always_comb begin
      push_dat  = bus.in_data[6:0];
      push_keep = 1'b1;
`ifdef KBD_UPCASE_EN
      if (bus.in_data[6:0] >= 7'h61 && bus.in_data[6:0] <= 7'h7A) begin
         push_dat[5] = 1'b0;
      end
      // LF is consumed from the source but never stored.
      if (bus.in_data[6:0] == 7'h0A) begin
         push_keep = 1'b0;
      end
`endif
   end

   assign full      = (level_q == LW'(FIFO_DEPTH));
   assign push_fire = bus.in_valid & ~full;
   assign wr_en     = push_fire & push_keep;

   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      gap_d    = gap_q;
      wait_d   = wait_q;
      ack_to_d = ack_to_q;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (level_q != '0) begin
               pop     = 1'b1;
               rd_d    = mem_q[rd_ptr_q];
               wait_d  = '0;
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            wait_d = wait_q + 1'b1;
            // Only an ack seen while da is already high retires the character.
            if (da_q && !rsync_n_q) begin
               state_d = ST_RELEASE;
            end else if ((ACK_TIMEOUT > 0) && (int'(wait_q) == ACK_TIMEOUT - 1)) begin
               ack_to_d = 1'b1;
               state_d  = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (rsync_n_q) begin
               gap_d   = GW'(GAP_CYCLES);
               state_d = ST_GAP;
            end
         end
         default: begin
            if (gap_q <= GW'(1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
      endcase
      // rd is loaded one cycle ahead of da so it is stable when da rises.
      da_d = (state_q == ST_PRESENT) && (state_d == ST_PRESENT);
   end

   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({wr_en, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge mr_n) begin
      if (!mr_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         state_q   <= ST_IDLE;
         rd_q      <= '0;
         da_q      <= 1'b0;
         ack_to_q  <= 1'b0;
         gap_q     <= '0;
         wait_q    <= '0;
         sync1_q   <= 1'b1;
         rsync_n_q <= 1'b1;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         state_q   <= state_d;
         rd_q      <= rd_d;
         da_q      <= da_d;
         ack_to_q  <= ack_to_d;
         gap_q     <= gap_d;
         wait_q    <= wait_d;
         sync1_q   <= bus.rda_n;
         rsync_n_q <= sync1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_dat;
      end
   end

   assign bus.in_ready    = ~full;
   assign bus.rd          = rd_q;
   assign bus.da          = da_q;
   assign bus.fifo_level  = level_q;
   assign bus.ack_timeout = ack_to_q;
endmodule
